// File: rtl/ldpc_link_pkg.sv
// Shared link constants and framer state encoding for the LDPC 16-bit link.
package ldpc_link_pkg;

    localparam logic [15:0] LINK_COMMA    = 16'h02bc;
    localparam logic [1:0]  CHARISK_COMMA = 2'b01;
    localparam logic [1:0]  CHARISK_DATA  = 2'b00;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

endpackage

// File: rtl/ldpc_frame_tx_if.sv
// Valid/ready payload stream from the encoder into the framer.
interface ldpc_frame_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ldpc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers and a
// registered fill level.
module ldpc_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_en,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              push;
    logic              pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ldpc_frame_tx.sv
// Transmit framer: buffers encoder words and releases whole frames only,
// filling the line with comma words between frames.
module ldpc_frame_tx
    import ldpc_link_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int MIN_GAP    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    ldpc_frame_tx_if.slave               up,
    input  logic                         tx_en,
    output logic [DATA_W-1:0]            tx_data,
    output logic [1:0]                   tx_charisk,
    output logic                         tx_sof,
    output logic                         tx_eof,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         payload_err
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [LVL_W-1:0] FRAME_LVL = LVL_W'(FRAME_LEN);
    localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);

    tx_state_t         state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_d;
    logic [1:0]        k_d;
    logic              sof_d;
    logic              eof_d;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    assign up.s_ready = !full;

    ldpc_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (up.s_data),
        .wr_en   (up.s_valid),
        .full    (full),
        .rd_data (head),
        .rd_en   (pop),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        data_d  = LINK_COMMA;
        k_d     = CHARISK_COMMA;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
                if (gap_q >= GAP_MAX && tx_en &&
                    fifo_level >= FRAME_LVL && !empty) begin
                    pop    = 1'b1;
                    data_d = head;
                    k_d    = CHARISK_DATA;
                    sof_d  = 1'b1;
                    cnt_d  = CNT_W'(1);
                    if (FRAME_LEN == 1) begin
                        eof_d = 1'b1;
                        gap_d = '0;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                pop    = 1'b1;
                data_d = head;
                k_d    = CHARISK_DATA;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    eof_d   = 1'b1;
                    state_d = IDLE;
                    gap_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also aborts any frame in flight; the FIFO is flushed alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            cnt_q       <= '0;
            tx_data     <= LINK_COMMA;
            tx_charisk  <= CHARISK_COMMA;
            tx_sof      <= 1'b0;
            tx_eof      <= 1'b0;
            payload_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            tx_data     <= data_d;
            tx_charisk  <= k_d;
            tx_sof      <= sof_d;
            tx_eof      <= eof_d;
            payload_err <= up.s_valid && up.s_ready &&
                           (up.s_data == LINK_COMMA);
        end
    end

endmodule

// File: tb/tb_ldpc_frame_tx.sv
// Directed self-checking bench for ldpc_frame_tx.
module tb_ldpc_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic [15:0] tx_data;
    logic [1:0]  tx_charisk;
    logic        tx_sof;
    logic        tx_eof;
    logic [6:0]  fifo_level;
    logic        payload_err;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ldpc_frame_tx_if #(.DATA_W(16)) up_if ();

    ldpc_frame_tx #(
        .DATA_W     (16),
        .FRAME_LEN  (16),
        .FIFO_DEPTH (64),
        .MIN_GAP    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .up          (up_if),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_charisk  (tx_charisk),
        .tx_sof      (tx_sof),
        .tx_eof      (tx_eof),
        .fifo_level  (fifo_level),
        .payload_err (payload_err)
    );

    always @(negedge clk) if (payload_err) err_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic [15:0] base, input int n,
                          input int bad_idx);
        for (int i = 0; i < n; i++) begin
            up_if.s_valid = 1'b1;
            up_if.s_data  = (i == bad_idx) ? 16'h02bc : base + 16'(i);
            tick();
        end
        up_if.s_valid = 1'b0;
    endtask

    task automatic recv_frame(input logic [15:0] base, input int bad_idx,
                              output int pre);
        int n;
        logic [15:0] w;
        pre = 0;
        n = 0;
        while (!tx_sof && n < 400) begin
            if (tx_charisk == 2'b01 && tx_data == 16'h02bc) pre++;
            tick();
            n++;
        end
        check("sof_seen", {31'd0, tx_sof}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            w = (i == bad_idx) ? 16'h02bc : base + 16'(i);
            check("frame_word", {tx_data, tx_charisk, tx_sof, tx_eof},
                  {w, 2'b00, i == 0, i == 15});
            tick();
        end
        check("post_comma", {tx_data, tx_charisk, tx_sof, tx_eof},
              {16'h02bc, 2'b01, 1'b0, 1'b0});
    endtask

    task automatic hold(input int cycles, output int non_comma,
                        output int sofs);
        non_comma = 0;
        sofs = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (tx_data != 16'h02bc || tx_charisk != 2'b01) non_comma++;
            if (tx_sof || tx_eof) sofs++;
        end
    endtask

    initial begin
        int pre;
        int nc;
        int sofs;
        int err0;
        int n;
        logic [6:0] lvl;

        rst = 1'b1;
        tx_en = 1'b0;
        up_if.s_valid = 1'b0;
        up_if.s_data = '0;
        repeat (3) tick();
        check("rst_data", tx_data, 16'h02bc);
        check("rst_k", tx_charisk, 2'b01);
        check("rst_sof_eof", {tx_sof, tx_eof}, 2'b00);
        check("rst_err", payload_err, 1'b0);
        check("rst_ready", up_if.s_ready, 1'b1);
        check("rst_level", fifo_level, 7'd0);
        rst = 1'b0;
        hold(3, nc, sofs);
        check("idle_commas", nc, 0);

        // single frame
        tx_en = 1'b1;
        err0 = err_cnt;
        fork
            push_n(16'h0001, 16, -1);
            recv_frame(16'h0001, -1, pre);
        join
        check("first_gap_min", pre >= 2, 1);
        check("b_level", fifo_level, 7'd0);
        check("b_no_err", err_cnt - err0, 0);

        // partial frame is held back
        push_n(16'h0101, 15, -1);
        hold(6, nc, sofs);
        check("hold_commas", nc, 0);
        check("hold_sof", sofs, 0);
        check("hold_level", fifo_level, 7'd15);
        up_if.s_valid = 1'b1;
        up_if.s_data = 16'h0110;
        tick();
        up_if.s_valid = 1'b0;
        check("c_level", fifo_level, 7'd16);
        recv_frame(16'h0101, -1, pre);
        check("c_latency", pre, 1);

        // fill to full, then back-to-back frames
        tx_en = 1'b0;
        push_n(16'h1000, 64, -1);
        check("full_ready", up_if.s_ready, 1'b0);
        check("full_level", fifo_level, 7'd64);
        up_if.s_valid = 1'b1;
        up_if.s_data = 16'hdead;
        tick();
        up_if.s_valid = 1'b0;
        check("full_reject", fifo_level, 7'd64);
        tx_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            recv_frame(16'h1000 + 16'(16 * f), -1, pre);
            check("b2b_gap", pre, (f == 0) ? 1 : 2);
        end
        check("d_level", fifo_level, 7'd0);

        // comma in payload, push during SEND
        err0 = err_cnt;
        push_n(16'h2000, 16, 4);
        check("e_level", fifo_level, 7'd16);
        fork
            recv_frame(16'h2000, 4, pre);
            begin
                tick();
                lvl = fifo_level;
                up_if.s_valid = 1'b1;
                up_if.s_data = 16'h3000;
                tick();
                up_if.s_valid = 1'b0;
                check("pp_before", lvl, 7'd15);
                check("pp_level", fifo_level, lvl);
            end
        join
        check("e_latency", pre, 1);
        check("e_err_once", err_cnt - err0, 1);
        check("e_leftover", fifo_level, 7'd1);

        // reset during a frame
        push_n(16'h3001, 15, -1);
        n = 0;
        while (!tx_sof && n < 50) begin
            tick();
            n++;
        end
        check("f_sof", {tx_sof, tx_data}, {1'b1, 16'h3000});
        repeat (7) tick();
        check("f_word8", {tx_data, tx_charisk, tx_eof},
              {16'h3007, 2'b00, 1'b0});
        rst = 1'b1;
        tick();
        check("f_rst_out", {tx_data, tx_charisk, tx_sof, tx_eof},
              {16'h02bc, 2'b01, 1'b0, 1'b0});
        check("f_rst_level", fifo_level, 7'd0);
        rst = 1'b0;
        hold(12, nc, sofs);
        check("f_after_commas", nc, 0);
        check("f_after_sof", sofs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldpc_frame_tx.md
Name: ldpc_frame_tx

Overview:
- Transmit-side framer for the 16-bit link whose receiver delimits frames with the comma word 16'h02bc.
- Buffers payload words from the upstream encoder in an internal synchronous FIFO.
- Sends a frame only when a complete frame of FRAME_LEN words is buffered, so a frame is never broken by underrun.
- Between frames it fills the line with comma words, which the receiver uses as start/stop delimiters.

Parameters:
- DATA_W, 16, link word width; only 16 is supported.
- FRAME_LEN, 16, payload words per frame; range 1..FIFO_DEPTH.
- FIFO_DEPTH, 64, internal buffer depth in words; power of 2, must be >= FRAME_LEN.
- MIN_GAP, 2, minimum comma words between consecutive frames; must be >= 1.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous reset, active-high.
- s_data  in  DATA_W  payload word from encoder.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block can accept a word; equals FIFO not full.
- tx_en  in  1  permits starting a new frame; a frame already in progress always completes.
- tx_data  out  DATA_W  registered link word.
- tx_charisk  out  2  K-char flags: 2'b01 for comma, 2'b00 for payload.
- tx_sof  out  1  high with the first payload word of a frame.
- tx_eof  out  1  high with the last payload word of a frame.
- fifo_level  out  log2(FIFO_DEPTH)+1  words currently buffered.
- payload_err  out  1  one-cycle pulse when an accepted word equals the comma.

Behaviour:
Reset values (rst high at a clk edge):
- tx_data=16'h02bc, tx_charisk=2'b01, tx_sof=0, tx_eof=0, payload_err=0.
- FIFO emptied, fifo_level=0.
- FSM=IDLE, gap_cnt=0, word_cnt=0.
- Reset mid-frame aborts the frame: the next output is a comma and the buffered words are discarded.

Write side:
- A word is accepted when s_valid && s_ready.
- s_ready = (fifo_level != FIFO_DEPTH).
- Simultaneous push and pop: fifo_level is unchanged; both operations take effect.

Payload check:
- An accepted word equal to 16'h02bc is still stored.
- payload_err pulses on the cycle after acceptance.
- The encoder must never produce this word; the pulse is a diagnostic only.

FSM IDLE:
- Every cycle drives tx_data=16'h02bc, tx_charisk=2'b01.
- gap_cnt increments and saturates at MIN_GAP.
- Go to SEND when gap_cnt>=MIN_GAP, tx_en=1 and fifo_level>=FRAME_LEN, all evaluated on the same edge.
- On that edge: pop the first word, emit it with tx_sof=1, set word_cnt=1.
- If FRAME_LEN==1, tx_eof=1 on the same word and the FSM returns to IDLE.

FSM SEND:
- Each cycle: pop the FIFO head (first-word-fall-through), register it onto tx_data with tx_charisk=2'b00, and increment word_cnt.
- When word_cnt reaches FRAME_LEN-1 at the edge, the word emitted is the last one: tx_eof=1, next state IDLE, gap_cnt=0.
- The FIFO cannot go empty during SEND, because entry required FRAME_LEN words.
- tx_en is ignored in SEND.

Latency:
- A word's earliest departure is 1 cycle after acceptance, when MIN_GAP is satisfied and a full frame is present.

Back-to-back frames:
- Exactly MIN_GAP commas separate consecutive frames when data is continuously available.

Wrap-around:
- FIFO pointers are log2(FIFO_DEPTH) bits plus a wrap bit; full/empty are derived from the pointers.
- fifo_level is registered and consistent with the pointers every cycle.

Decomposition:
- Package ldpc_link_pkg:
  - LINK_COMMA = 16'h02bc
  - CHARISK_COMMA = 2'b01
  - CHARISK_DATA = 2'b00
  - FSM state encoding {IDLE, SEND}
- Sub-module ldpc_sync_fifo: single-clock first-word-fall-through FIFO with parameters DATA_W and DEPTH, level output, synchronous active-high reset. It is reusable by the receive path.

Test Plan:
- Reset then idle: rst high for 3 cycles, no input -> tx_data=16'h02bc and tx_charisk=2'b01 every cycle, s_ready=1, fifo_level=0.
- Single frame: push 16 words 16'h0001..16'h0010 with tx_en=1 ->
  - first payload word no earlier than 2 comma cycles after reset;
  - 16'h0001 with tx_sof=1, then 16'h0002..16'h0010 on consecutive cycles;
  - tx_eof with 16'h0010;
  - then commas again.
- Partial frame hold: push 15 words -> commas only. Push a 16th word -> frame starts within 1 cycle of the level reaching 16.
- Back-to-back and full: push 64 words with tx_en=0 ->
  - s_ready=0 and fifo_level=64;
  - the 65th s_valid word is not accepted.
  - Raise tx_en -> 4 frames, each separated by exactly 2 commas; fifo_level returns to 0.
- Illegal payload and simultaneous push/pop:
  - push 16'h02bc as word 5 -> payload_err pulses once and the frame still carries 16 words.
  - Push during SEND -> fifo_level unchanged on that cycle.
- Reset mid-frame: assert rst at the 8th payload word -> next output is a comma with tx_charisk=2'b01, fifo_level=0, no tx_eof.
